// File: rtl/spi_slave_aes_port.sv
// spi_slave_aes_port: SPI mode-0 slave (MSB first) that receives a block and key,
// starts an AES core, holds its result and shifts it back out on the next frame.
// Optional feature macro: SPI_SLAVE_OPCODE_EN (8-bit opcode prefix, core_decrypt_o output).
module spi_slave_aes_port #(
    parameter int Nk          = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sclk_i,
    input  logic                 cs_n_i,
    input  logic                 mosi_i,
    output logic                 miso_o,
    output logic [127:0]         core_data_o,
    output logic [Nk*32-1:0]     core_key_o,
    output logic                 core_start_o,
    input  logic                 core_done_i,
    input  logic [127:0]         core_result_i,
    output logic                 busy_o,
    output logic                 result_valid_o,
`ifdef SPI_SLAVE_OPCODE_EN
    output logic                 frame_err_o,
    output logic                 core_decrypt_o
`else
    output logic                 frame_err_o
`endif
);

    localparam int KEY_BITS = Nk * 32;
`ifdef SPI_SLAVE_OPCODE_EN
    localparam int OP_BITS = 8;
`else
    localparam int OP_BITS = 0;
`endif
    localparam int         FRAME_BITS = 128 + KEY_BITS + OP_BITS;
    localparam logic [8:0] FRAME_CNT  = 9'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        START = 2'd2,
        BUSY  = 2'd3
    } state_t;

    // One extra flop on sclk/cs_n holds the previous synced sample for edge detection.
    logic [SYNC_STAGES:0]   sclk_sync_q;
    logic [SYNC_STAGES:0]   cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s, opcode_ok;

    state_t                  state_q, state_d;
    logic [8:0]              cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   rx_q, rx_d;
    logic [127:0]            tx_q, tx_d;
    logic [127:0]            result_q, result_d;
    logic                    result_valid_q, result_valid_d;
    logic                    reject_q, reject_d;
    logic                    frame_err_q, frame_err_d;
    logic [127:0]            core_data_q, core_data_d;
    logic [KEY_BITS-1:0]     core_key_q, core_key_d;
`ifdef SPI_SLAVE_OPCODE_EN
    logic                    decrypt_q, decrypt_d;
`endif

    // Synchronise the SPI pins into the clk domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-1:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        end
    end

    assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES];
    assign cs_fall   = ~cs_sync_q[SYNC_STAGES-1] & cs_sync_q[SYNC_STAGES];
    assign cs_rise   = cs_sync_q[SYNC_STAGES-1] & ~cs_sync_q[SYNC_STAGES];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

`ifdef SPI_SLAVE_OPCODE_EN
    assign opcode_ok = (rx_q[FRAME_BITS-1 -: 7] == 7'd0);
`else
    assign opcode_ok = 1'b1;
`endif

    // Frame FSM next-state and datapath updates.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rx_d           = rx_q;
        tx_d           = tx_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        reject_d       = reject_q;
        frame_err_d    = 1'b0;
        core_data_d    = core_data_q;
        core_key_d     = core_key_q;
`ifdef SPI_SLAVE_OPCODE_EN
        decrypt_d      = decrypt_q;
`endif
        // A frame opened while the core was busy is silently ignored until its cs_n rise.
        if (reject_q && cs_rise) begin
            reject_d    = 1'b0;
            frame_err_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (cs_fall && !reject_q) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    rx_d    = '0;
                    tx_d    = result_valid_q ? result_q : '0;
                end
            end
            RECV: begin
                if (sclk_rise && cnt_q != FRAME_CNT) begin
                    rx_d  = {rx_q[FRAME_BITS-2:0], mosi_s};
                    cnt_d = cnt_q + 9'd1;
                end
                if (sclk_fall) begin
                    tx_d = {tx_q[126:0], 1'b0};
                end
                if (cs_rise) begin
                    if (cnt_q == FRAME_CNT && opcode_ok) begin
                        // Operands are latched on entry so they are stable during the start pulse.
                        state_d        = START;
                        result_valid_d = 1'b0;
                        core_data_d    = rx_q[KEY_BITS +: 128];
                        core_key_d     = rx_q[KEY_BITS-1:0];
`ifdef SPI_SLAVE_OPCODE_EN
                        decrypt_d      = rx_q[FRAME_BITS-8];
`endif
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
                end
            end
            START: begin
                state_d = BUSY;
                if (cs_fall) reject_d = 1'b1;
            end
            BUSY: begin
                // Capture wins over a frame opening in the same cycle; that frame is rejected.
                if (core_done_i) begin
                    result_d       = core_result_i;
                    result_valid_d = 1'b1;
                    state_d        = IDLE;
                end
                if (cs_fall) reject_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rx_q           <= '0;
            tx_q           <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            reject_q       <= 1'b0;
            frame_err_q    <= 1'b0;
            core_data_q    <= '0;
            core_key_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rx_q           <= rx_d;
            tx_q           <= tx_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            reject_q       <= reject_d;
            frame_err_q    <= frame_err_d;
            core_data_q    <= core_data_d;
            core_key_q     <= core_key_d;
        end
    end

`ifdef SPI_SLAVE_OPCODE_EN
    // Decrypt select, held from one START to the next.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) decrypt_q <= 1'b0;
        else         decrypt_q <= decrypt_d;
    end
    assign core_decrypt_o = decrypt_q;
`endif

    assign miso_o         = (state_q == RECV) && (cnt_q != FRAME_CNT) && tx_q[127];
    assign core_data_o    = core_data_q;
    assign core_key_o     = core_key_q;
    assign core_start_o   = (state_q == START);
    assign busy_o         = (state_q == START) || (state_q == BUSY);
    assign result_valid_o = result_valid_q;
    assign frame_err_o    = frame_err_q;

endmodule

// File: doc/spi_slave_aes_port.md
Name: spi_slave_aes_port

Overview:
- SPI slave (mode 0, MSB first) that terminates the link driven by SPI_Master.
- Receives a 128-bit block plus Nk*32-bit key, pulses the AES core, and captures the core result.
- Shifts the result back on MISO during the next chip-select frame.
- Sits between the SPI pins and the Encryption/Decryption cores on the device side.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8); key frame width = Nk*32.
- SYNC_STAGES, 2, flops in each sclk/cs_n/mosi synchroniser (≥2).

Ports:
- clk  in  1  system clock; must be ≥8× sclk.
- reset  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from master, async to clk.
- cs_n  in  1  SPI chip select, active-low.
- mosi  in  1  SPI data master→slave.
- miso  out  1  SPI data slave→master.
- core_data  out  128  block presented to the AES core.
- core_key  out  Nk*32  key presented to the AES core.
- core_start  out  1  one-clk start pulse to the core.
- core_done  in  1  core completion, level or pulse.
- core_result  in  128  core output, valid while core_done=1.
- busy  out  1  high from core_start until result captured.
- result_valid  out  1  result held, waiting to be shifted out.
- frame_err  out  1  one-clk pulse on an aborted or rejected frame.

Behaviour:
- Reset (reset=0, async):
  - miso, core_start, busy, result_valid, frame_err = 0.
  - core_data, core_key, shift registers and bit counter cleared.
  - State = IDLE.
- Synchronisation:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - Rising and falling sclk edges are detected from the last two synced samples.
  - Pin-to-action latency: SYNC_STAGES+1 clk.
- Frame:
  - Starts on the synced cs_n falling edge.
  - FRAME_BITS = 128 + Nk*32 (+8 with opcode feature).
  - Bit order: data MSB first, then key MSB first.
  - mosi sampled on sclk rise; miso updated on sclk fall.
  - First tx bit is driven combinationally as tx_shift[127] while cs_n is low.
  - Bit counter is 9 bits wide and saturates at FRAME_BITS; bits beyond FRAME_BITS are ignored and miso=0.
- States:
  - IDLE: waits for cs_n falling edge → RECV. Load tx_shift with the held result if result_valid=1, else with 0.
  - RECV: shift mosi into rx_shift.
    - cs_n rises with count==FRAME_BITS → START. result_valid clears if it was set (result delivered).
    - cs_n rises with count<FRAME_BITS → frame_err pulse, back to IDLE. rx discarded; result_valid and held result unchanged.
  - START: core_data/core_key ← rx_shift fields, core_start=1 for exactly one clk, busy=1 → BUSY.
  - BUSY: wait for core_done=1; capture core_result into result_reg, busy=0, result_valid=1 → IDLE.
    - core_done sampled only in BUSY; a core_done in the START cycle is ignored.
    - Frames during BUSY: miso=0, no data captured, frame_err pulse at cs_n rise.
- Simultaneous events:
  - core_done and cs_n falling in the same clk: capture takes priority. The frame that started in that clk is treated as during-BUSY (rejected).
- Master reads result without new work: send a full frame of dummy data. This always restarts the core; there is no read-only frame.
- core_data and core_key hold their values until the next START.
- miso is not tri-stated; the board-level buffer uses cs_n.

Optional Feature:
- Macro: SPI_SLAVE_OPCODE_EN.
- Defined:
  - The frame is prefixed by an 8-bit opcode (MSB first) before the data.
  - Extra output core_decrypt (1 bit) = opcode[0], latched in START and held until the next START.
  - Opcode bits [7:1] must be 0; otherwise the frame is rejected with frame_err at cs_n rise and no START.
- Undefined: no opcode, no core_decrypt port; FRAME_BITS = 128 + Nk*32.

Test Plan:
- Nk=4, send data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → one core_start pulse. core_data/core_key match the inputs. Core model returns 69c4e0d86a7b0430d8cdb78070b4c55a → result_valid=1.
- Following frame → first 128 miso bits = 69c4e0d86a7b0430d8cdb78070b4c55a MSB first; result_valid clears at that frame's cs_n rise.
- Nk=8, key 000102…1e1f with same data → FRAME_BITS=384; core_key width 256 matches; result 8ea2b7ca516745bfeafc49904b496089 read back.
- cs_n raised after 100 bits → frame_err single pulse, no core_start, previous result_valid/result_reg unchanged.
- Frame sent while busy=1 (core_done held low 500 clk) → miso=0 throughout, frame_err at cs_n rise, core_start count unchanged.
- reset pulled low mid-RECV and mid-BUSY → all outputs 0 within the same clk. A subsequent full frame works normally.
- With SPI_SLAVE_OPCODE_EN: opcode 01 → core_decrypt=1; opcode 02 → frame_err, no start.
